// File: rtl/mips_regfile_pkg.sv
// Shared constants for the multi-read-port MIPS register file.
package mips_regfile_pkg;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  localparam logic [31:0] ZERO_REG = '0;

endpackage

// File: rtl/mips_regfile_clear_fsm.sv
// Post-reset clear engine: walks every entry once, then raises ready.
//   state    | meaning
//   ST_CLEAR | writing zero to entry clr_ptr, one entry per cycle
//   ST_RUN   | clear finished, port reads/writes accepted until next rst
module mips_regfile_clear_fsm
  import mips_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic            state_q, state_d;
  logic [ADDR_W:0] clr_ptr_q, clr_ptr_d;
  logic            ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == CLR_LAST) state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_comb begin
    clr_we   = (state_q == ST_CLEAR);
    clr_addr = clr_ptr_q[ADDR_W-1:0];
    ready    = ready_q;
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero and a post-reset clear engine.
// Define MIPS_REGFILE_BYPASS_EN for write-first same-cycle read/write; default is read-first.
module mips_regfile_mp
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_en,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     signal_reg_write,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              port_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  mips_regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Clear engine owns the write port until ready; rst drops any in-flight write.
  always_comb begin
    port_we = ready && signal_reg_write && (write_reg != ZERO_ADDR);
    wr_en   = 1'b0;
    wr_addr = write_reg;
    wr_data = write_data;
    if (rst) begin
      wr_en = 1'b0;
    end else if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (port_we) begin
      wr_en = 1'b1;
    end
  end

  // No reset on the array so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_d, rd_q;
    logic              byp_hit;

    assign addr = read_reg[p*ADDR_W +: ADDR_W];

`ifdef MIPS_REGFILE_BYPASS_EN
    // port_we already excludes r0 and CLEAR.
    assign byp_hit = port_we && (write_reg == addr);
`else
    assign byp_hit = 1'b0;
`endif

    always_comb begin
      rd_d = rd_q;
      if (!ready) begin
        rd_d = '0;
      end else if (read_en) begin
        if (addr == ZERO_ADDR) rd_d = '0;
        else if (byp_hit)      rd_d = write_data;
        else                   rd_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign read_data[p*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (default parameters, two read ports).
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [9:0]  read_reg;
  logic [63:0] read_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  mips_regfile_mp dut (
    .clk              (clk),
    .rst              (rst),
    .read_en          (read_en),
    .read_reg         (read_reg),
    .read_data        (read_data),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .ready            (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_reg        = a;
    write_data       = d;
    signal_reg_write = 1'b1;
    tick();
    signal_reg_write = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    read_reg = {a1, a0};
    read_en  = 1'b1;
    tick();
    read_en  = 1'b0;
  endtask

  // Count cycles until ready, bounded so a stuck clear still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; read_reg = '0;
    write_reg = '0; write_data = '0; signal_reg_write = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd0", read_data[31:0], 32'd0);
    check("rst_rd1", read_data[63:32], 32'd0);
    rst = 1'b0;
    wait_ready(cnt);
    check("clr_len", cnt, 32'd32);

    for (int a = 0; a < 32; a += 2) begin
      rd2(5'(a), 5'(a + 1));
      check($sformatf("clr_r%0d", a), read_data[31:0], 32'd0);
      check($sformatf("clr_r%0d", a + 1), read_data[63:32], 32'd0);
    end

    wr(5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd5);
    check("rw_p0", read_data[31:0], 32'hDEADBEEF);
    check("rw_p1", read_data[63:32], 32'hDEADBEEF);

    wr(5'd0, 32'hFFFFFFFF);
    rd2(5'd0, 5'd5);
    check("r0_rd", read_data[31:0], 32'd0);
    check("r0_other", read_data[63:32], 32'hDEADBEEF);

    wr(5'd7, 32'h00000001);
    write_reg = 5'd7; write_data = 32'h12345678; signal_reg_write = 1'b1;
    read_reg = {5'd0, 5'd7}; read_en = 1'b1;
    tick();
    signal_reg_write = 1'b0; read_en = 1'b0;
`ifdef MIPS_REGFILE_BYPASS_EN
    check("byp_same", read_data[31:0], 32'h12345678);
`else
    check("byp_same", read_data[31:0], 32'h00000001);
`endif
    check("byp_r0", read_data[63:32], 32'd0);
    rd2(5'd7, 5'd7);
    check("byp_next", read_data[31:0], 32'h12345678);

    write_reg = 5'd0; write_data = 32'hCAFEF00D; signal_reg_write = 1'b1;
    read_reg = {5'd0, 5'd0}; read_en = 1'b1;
    tick();
    signal_reg_write = 1'b0; read_en = 1'b0;
    check("r0_byp", read_data[31:0], 32'd0);

    rd2(5'd7, 5'd5);
    read_reg = {5'd5, 5'd5};
    wr(5'd5, 32'h11111111);
    tick();
    check("hold_p0", read_data[31:0], 32'h12345678);
    check("hold_p1", read_data[63:32], 32'hDEADBEEF);
    rd2(5'd5, 5'd7);
    check("hold_after", read_data[31:0], 32'h11111111);

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    write_reg = 5'd9; write_data = 32'hA5A5A5A5; signal_reg_write = 1'b1;
    read_reg = {5'd9, 5'd9}; read_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("clr_force0", read_data[31:0], 32'd0);
    check("clr_ready0", {31'd0, ready}, 32'd0);
    cnt = 5;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    signal_reg_write = 1'b0; read_en = 1'b0;
    check("clr2_len", cnt, 32'd32);
    rd2(5'd9, 5'd5);
    check("clr_wr_r9", read_data[31:0], 32'd0);
    check("clr_r5", read_data[63:32], 32'd0);

    wr(5'd3, 32'h00000055);
    rd2(5'd3, 5'd3);
    check("mid_pre", read_data[31:0], 32'h00000055);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick();
    check("mid_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    wait_ready(cnt);
    check("mid_len", cnt, 32'd32);
    rd2(5'd3, 5'd31);
    check("mid_r3", read_data[31:0], 32'd0);
    check("mid_r31", read_data[63:32], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
